// File: rtl/beat_scheduler.sv
// rtl/beat_scheduler.sv - beat timebase sequencer: lead-in, play, pause and done phases over a tick divider
// Optional tempo ramp during play is enabled by defining BEAT_SCHED_SPEEDUP_EN.
module beat_scheduler #(
  parameter int DIV_W      = 4,
  parameter int BEAT_W     = 8,
  parameter int LEADIN     = 3,
  parameter int SONG_BEATS = 64,
  parameter int MIN_DIV    = 2,
  parameter int RAMP_BEATS = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              tick_en,
  input  logic              start,
  input  logic              pause_tgl,
  input  logic              stop,
  input  logic [DIV_W-1:0]  tempo,
  output logic              beat,
  output logic              leadin_beat,
  output logic              done,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [2:0]        state,
  output logic [DIV_W-1:0]  cur_div,
  output logic [DIV_W-1:0]  div_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEADIN = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSE  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

`ifdef BEAT_SCHED_SPEEDUP_EN
  localparam bit SpeedupEn = 1'b1;
`else
  localparam bit SpeedupEn = 1'b0;
`endif

  localparam int LC_W = (LEADIN < 2) ? 1 : $clog2(LEADIN + 1);
  localparam int RampDiv = (RAMP_BEATS > 0) ? RAMP_BEATS : 1;
  localparam logic [DIV_W-1:0]  MinDiv  = DIV_W'(MIN_DIV);
  localparam logic [LC_W-1:0]   LeadinN = LC_W'(LEADIN);
  localparam logic [BEAT_W-1:0] LastIdx = BEAT_W'(SONG_BEATS - 1);
  localparam logic [BEAT_W-1:0] RampN   = BEAT_W'(RampDiv);
  // With no count-in the song starts straight in play.
  localparam state_e StartState = (LEADIN == 0) ? S_PLAY : S_LEADIN;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic              beat_q, beat_d;
  logic              leadin_beat_q, leadin_beat_d;
  logic              done_q, done_d;
  logic [BEAT_W-1:0] idx_q, idx_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [DIV_W-1:0]  cdiv_q, cdiv_d;
  logic [DIV_W-1:0]  dcnt_q, dcnt_d;
  logic [BEAT_W-1:0] idx_inc;
  logic [LC_W-1:0]   lcnt_inc;
  logic              active;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    beat_d        = 1'b0;
    leadin_beat_d = 1'b0;
    done_d        = 1'b0;
    idx_d         = idx_q;
    lcnt_d        = lcnt_q;
    cdiv_d        = cdiv_q;
    dcnt_d        = dcnt_q;
    idx_inc       = idx_q + 1'b1;
    lcnt_inc      = lcnt_q + 1'b1;
    active        = (state_q == S_LEADIN) || (state_q == S_PLAY);

    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      lcnt_d  = '0;
      dcnt_d  = '0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = StartState;
      cdiv_d  = (tempo < MinDiv) ? MinDiv : tempo;
      idx_d   = '0;
      lcnt_d  = '0;
      dcnt_d  = '0;
    end else if (pause_tgl && active) begin
      ret_d   = state_q;
      state_d = S_PAUSE;
    end else if (pause_tgl && state_q == S_PAUSE) begin
      state_d = ret_q;
    end else if (tick_en && active) begin
      if (dcnt_q == cdiv_q) begin
        dcnt_d = '0;
        if (state_q == S_LEADIN) begin
          leadin_beat_d = 1'b1;
          lcnt_d        = lcnt_inc;
          if (lcnt_inc == LeadinN) state_d = S_PLAY;
        end else begin
          beat_d = 1'b1;
          idx_d  = idx_inc;
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          // Tempo ramp: the shorter period takes effect from the next beat.
          if (SpeedupEn && idx_inc != '0 && (idx_inc % RampN) == '0 && cdiv_q > MinDiv)
            cdiv_d = cdiv_q - 1'b1;
        end
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= S_IDLE;
      ret_q         <= S_LEADIN;
      beat_q        <= 1'b0;
      leadin_beat_q <= 1'b0;
      done_q        <= 1'b0;
      idx_q         <= '0;
      lcnt_q        <= '0;
      cdiv_q        <= MinDiv;
      dcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      beat_q        <= beat_d;
      leadin_beat_q <= leadin_beat_d;
      done_q        <= done_d;
      idx_q         <= idx_d;
      lcnt_q        <= lcnt_d;
      cdiv_q        <= cdiv_d;
      dcnt_q        <= dcnt_d;
    end
  end

  assign beat        = beat_q;
  assign leadin_beat = leadin_beat_q;
  assign done        = done_q;
  assign beat_idx    = idx_q;
  assign state       = state_q;
  assign cur_div     = cdiv_q;
  assign div_cnt     = dcnt_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// tb/tb_beat_scheduler.sv - scoreboard bench for beat_scheduler: song timing, clamp, pause, collisions, reset, ramp
`timescale 1ns/1ps
module tb_beat_scheduler;
  localparam int DIV_W = 4, BEAT_W = 8, LEADIN = 3, SONG_BEATS = 4, MIN_DIV = 2, RAMP_BEATS = 2;

  logic clk = 1'b0, clr_n = 1'b0, tick_en = 1'b0, start = 1'b0, pause_tgl = 1'b0, stop = 1'b0;
  logic [DIV_W-1:0]  tempo = '0;
  logic              beat, leadin_beat, done;
  logic [BEAT_W-1:0] beat_idx;
  logic [2:0]        state;
  logic [DIV_W-1:0]  cur_div, div_cnt;

  int n_cmp = 0, n_mis = 0, cyc = 0, t0 = 0;
  bit sb_en = 1'b0;

  typedef struct { logic [2:0] kind; int rel; int idx; } exp_t;
  exp_t exp_q[$];
  exp_t me;

  beat_scheduler #(.DIV_W(DIV_W), .BEAT_W(BEAT_W), .LEADIN(LEADIN), .SONG_BEATS(SONG_BEATS),
                   .MIN_DIV(MIN_DIV), .RAMP_BEATS(RAMP_BEATS)) dut (
    .clk(clk), .clr_n(clr_n), .tick_en(tick_en), .start(start), .pause_tgl(pause_tgl),
    .stop(stop), .tempo(tempo), .beat(beat), .leadin_beat(leadin_beat), .done(done),
    .beat_idx(beat_idx), .state(state), .cur_div(cur_div), .div_cnt(div_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000ns");
    $fatal(1);
  end

  // Every pulse {done,beat,leadin_beat} must match the next expected event in kind, time and index.
  always @(negedge clk) begin
    if (sb_en && (beat || leadin_beat || done)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL sb_extra: got pulse %b at rel %0d, required none", {done, beat, leadin_beat}, cyc - t0);
      end else begin
        me = exp_q.pop_front();
        if ({done, beat, leadin_beat} !== me.kind || (cyc - t0) != me.rel || int'(beat_idx) != me.idx) begin
          n_mis++;
          $display("FAIL sb_event: got pulse %b rel %0d idx %0d, required pulse %b rel %0d idx %0d",
                   {done, beat, leadin_beat}, cyc - t0, beat_idx, me.kind, me.rel, me.idx);
        end
      end
    end
  end

  task automatic gen_song(input int tmp, output int last_rel, output int fin_div);
    int cd, t;
    cd = (tmp < MIN_DIV) ? MIN_DIV : tmp;
    t = 0;
    for (int k = 1; k <= LEADIN; k++) begin
      t += cd + 1;
      exp_q.push_back('{3'b001, t, 0});
    end
    for (int b = 1; b <= SONG_BEATS; b++) begin
      t += cd + 1;
      exp_q.push_back('{(b == SONG_BEATS) ? 3'b110 : 3'b010, t, b});
`ifdef BEAT_SCHED_SPEEDUP_EN
      if (b % RAMP_BEATS == 0 && cd > MIN_DIV) cd--;
`endif
    end
    last_rel = t;
    fin_div = cd;
  endtask

  task automatic start_song(input logic [DIV_W-1:0] t);
    @(negedge clk);
    tempo = t;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 3'd0) begin n_mis++; $display("FAIL reset_state: got %0d, required 0", state); end
    n_cmp++; if ({beat, leadin_beat, done} !== 3'b000) begin n_mis++; $display("FAIL reset_pulses: got %b, required 000", {beat, leadin_beat, done}); end
    n_cmp++; if (beat_idx !== '0) begin n_mis++; $display("FAIL reset_idx: got %0d, required 0", beat_idx); end
    n_cmp++; if (div_cnt !== '0) begin n_mis++; $display("FAIL reset_div_cnt: got %0d, required 0", div_cnt); end
    n_cmp++; if (cur_div !== 4'd2) begin n_mis++; $display("FAIL reset_cur_div: got %0d, required 2", cur_div); end
    clr_n = 1'b1;
    @(negedge clk);
    tick_en = 1'b1;
  endtask

  task automatic test_basic_song();
    int last, fd;
    exp_q.delete();
    gen_song(3, last, fd);
    sb_en = 1'b1;
    start_song(4'd3);
    n_cmp++; if (cur_div !== 4'd3) begin n_mis++; $display("FAIL basic_cur_div: got %0d, required 3", cur_div); end
    for (int i = 0; i < last + 10 && state !== 3'd4; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 3'd4) begin n_mis++; $display("FAIL basic_done_state: got %0d, required 4", state); end
    n_cmp++; if (beat_idx !== 8'd4) begin n_mis++; $display("FAIL basic_idx: got %0d, required 4", beat_idx); end
    n_cmp++; if (cur_div !== DIV_W'(fd)) begin n_mis++; $display("FAIL basic_final_div: got %0d, required %0d", cur_div, fd); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
    n_cmp++; if (state !== 3'd4 || beat_idx !== 8'd4) begin n_mis++; $display("FAIL done_pause_ignored: got state %0d idx %0d, required 4 4", state, beat_idx); end
    sb_en = 1'b0;
  endtask

  task automatic test_clamp();
    int last, fd;
    exp_q.delete();
    gen_song(0, last, fd);
    sb_en = 1'b1;
    start_song(4'd0);
    n_cmp++; if (cur_div !== 4'd2) begin n_mis++; $display("FAIL clamp_cur_div: got %0d, required 2", cur_div); end
    for (int i = 0; i < last + 10 && state !== 3'd4; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 3'd4 || beat_idx !== 8'd4) begin n_mis++; $display("FAIL clamp_done: got state %0d idx %0d, required 4 4", state, beat_idx); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL clamp_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    sb_en = 1'b0;
  endtask

  task automatic test_pause();
    int bad;
    logic [BEAT_W-1:0] saved;
    start_song(4'd3);
    for (int i = 0; i < 40 && !(state === 3'd2 && div_cnt === 4'd2); i++) @(negedge clk);
    n_cmp++; if (state !== 3'd2 || div_cnt !== 4'd2) begin n_mis++; $display("FAIL pause_reach: got state %0d div %0d, required 2 2", state, div_cnt); end
    saved = beat_idx;
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
    n_cmp++; if (state !== 3'd3 || div_cnt !== 4'd2) begin n_mis++; $display("FAIL pause_enter: got state %0d div %0d, required 3 2", state, div_cnt); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (state !== 3'd3 || cur_div !== 4'd3) begin n_mis++; $display("FAIL pause_start_ignored: got state %0d div %0d, required 3 3", state, cur_div); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (div_cnt !== 4'd2 || beat_idx !== saved || beat !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL pause_frozen: got %0d bad cycles, required 0", bad); end
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
    n_cmp++; if (state !== 3'd2 || div_cnt !== 4'd2) begin n_mis++; $display("FAIL pause_resume: got state %0d div %0d, required 2 2", state, div_cnt); end
    @(negedge clk);
    n_cmp++; if (beat !== 1'b0 || div_cnt !== 4'd3) begin n_mis++; $display("FAIL resume_tick1: got beat %b div %0d, required 0 3", beat, div_cnt); end
    @(negedge clk);
    n_cmp++; if (beat !== 1'b1 || beat_idx !== saved + 1'b1) begin n_mis++; $display("FAIL resume_beat: got beat %b idx %0d, required 1 %0d", beat, beat_idx, saved + 1'b1); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_collision();
    start_song(4'd3);
    for (int i = 0; i < 40 && !(state === 3'd2 && div_cnt === cur_div); i++) @(negedge clk);
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
    n_cmp++; if (beat !== 1'b0 || state !== 3'd3 || div_cnt !== 4'd3 || beat_idx !== 8'd0) begin n_mis++; $display("FAIL coll_pause: got beat %b state %0d div %0d idx %0d, required 0 3 3 0", beat, state, div_cnt, beat_idx); end
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
    @(negedge clk);
    n_cmp++; if (beat !== 1'b1 || beat_idx !== 8'd1 || div_cnt !== 4'd0) begin n_mis++; $display("FAIL coll_after_resume: got beat %b idx %0d div %0d, required 1 1 0", beat, beat_idx, div_cnt); end
    for (int i = 0; i < 10 && !(state === 3'd2 && div_cnt === cur_div); i++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++; if ({beat, leadin_beat, done} !== 3'b000 || state !== 3'd0) begin n_mis++; $display("FAIL coll_stop: got pulses %b state %0d, required 000 0", {beat, leadin_beat, done}, state); end
    n_cmp++; if (div_cnt !== '0 || beat_idx !== '0 || cur_div !== 4'd3) begin n_mis++; $display("FAIL coll_stop_cnt: got div %0d idx %0d cur %0d, required 0 0 3", div_cnt, beat_idx, cur_div); end
  endtask

  task automatic test_async_reset();
    int last, fd;
    start_song(4'd3);
    for (int i = 0; i < 40 && beat_idx == 0; i++) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0 || {beat, leadin_beat, done} !== 3'b000) begin n_mis++; $display("FAIL areset_state: got state %0d pulses %b, required 0 000", state, {beat, leadin_beat, done}); end
    n_cmp++; if (beat_idx !== '0 || div_cnt !== '0 || cur_div !== 4'd2) begin n_mis++; $display("FAIL areset_cnt: got idx %0d div %0d cur %0d, required 0 0 2", beat_idx, div_cnt, cur_div); end
    @(negedge clk);
    clr_n = 1'b1;
    exp_q.delete();
    gen_song(3, last, fd);
    sb_en = 1'b1;
    start_song(4'd3);
    for (int i = 0; i < last + 10 && state !== 3'd4; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 3'd4 || beat_idx !== 8'd4) begin n_mis++; $display("FAIL areset_song: got state %0d idx %0d, required 4 4", state, beat_idx); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL areset_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    sb_en = 1'b0;
  endtask

  task automatic test_speedup();
    int last, fd;
    logic [DIV_W-1:0] mid;
`ifdef BEAT_SCHED_SPEEDUP_EN
    mid = 4'd3;
`else
    mid = 4'd4;
`endif
    exp_q.delete();
    gen_song(4, last, fd);
    sb_en = 1'b1;
    start_song(4'd4);
    for (int i = 0; i < last + 10 && beat_idx != 8'd2; i++) @(negedge clk);
    n_cmp++; if (beat_idx !== 8'd2 || cur_div !== mid) begin n_mis++; $display("FAIL speed_mid: got idx %0d cur %0d, required 2 %0d", beat_idx, cur_div, mid); end
    for (int i = 0; i < last + 10 && state !== 3'd4; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (cur_div !== DIV_W'(fd)) begin n_mis++; $display("FAIL speed_final: got %0d, required %0d", cur_div, fd); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL speed_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    sb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_song();
    test_clamp();
    test_pause();
    test_collision();
    test_async_reset();
    test_speedup();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
